// File: rtl/bram_arb_ctrl_pkg.sv
// Shared constants and helpers for the BRAM arbiter controller.
// ADDR_MODE encodings, byte-count derivation and channel-tag width.
package bram_arb_ctrl_pkg;

  localparam int ADDR_MODE_WORD   = 0;
  localparam int ADDR_MODE_BYTE32 = 2;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  function automatic int num_byte(input int dat_width);
    return dat_width / 8;
  endfunction

  // A single-channel build still needs a 1-bit tag.
  function automatic int tag_width(input int num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/bram_arb_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// found at or after ptr, wrapping around.
module rr_arbiter
  import bram_arb_ctrl_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int TAG_W = tag_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [TAG_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant
);

  logic [NUM_CH-1:0] req_rot;
  logic [NUM_CH-1:0] gnt_rot;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  assign req_rot = NUM_CH'({req, req} >> ptr);
  assign gnt_rot = req_rot & (-req_rot);
  assign grant   = NUM_CH'(({gnt_rot, gnt_rot} << ptr) >> NUM_CH);

endmodule

// File: rtl/bram_arb_ctrl.sv
// Multi-channel round-robin front end for a single BRAM port with read return.
// Define BRAM_ARB_CTRL_ODAT_HOLD_EN to keep the last returned word per channel on odat.
module bram_arb_ctrl
  import bram_arb_ctrl_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DAT_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ADDR_MODE  = ADDR_MODE_BYTE32,
  parameter int MEM_DELAY  = 2,
  localparam int NUM_BYTE  = num_byte(DAT_WIDTH),
  localparam int TAG_W     = tag_width(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_CH-1:0]            req_wren,
  input  logic [NUM_CH*NUM_BYTE-1:0]   req_be,
  input  logic [NUM_CH*DAT_WIDTH-1:0]  req_idat,
  input  logic [NUM_CH-1:0]            req_rden,
  output logic [NUM_CH-1:0]            req_rdy,
  output logic [NUM_CH*DAT_WIDTH-1:0]  odat,
  output logic [NUM_CH-1:0]            oval,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [DAT_WIDTH-1:0]         mem_idat,
  input  logic [DAT_WIDTH-1:0]         mem_odat,
  output logic [NUM_BYTE-1:0]          mem_wren,
  output logic                         mem_enb,
  output logic                         mem_rst
);

  logic [NUM_CH-1:0]     req_any;
  logic [NUM_CH-1:0]     grant;
  logic                  accept;
  logic                  gnt_wr;
  logic [TAG_W-1:0]      ptr_reg, ptr_next;
  logic [TAG_W-1:0]      tag_chain  [NUM_CH+1];
  logic [ADDR_WIDTH-1:0] addr_chain [NUM_CH+1];
  logic [DAT_WIDTH-1:0]  dat_chain  [NUM_CH+1];
  logic [NUM_BYTE-1:0]   be_chain   [NUM_CH+1];

  logic                  iss_val_reg;
  op_e                   iss_op_reg;
  logic [TAG_W-1:0]      iss_tag_reg;
  logic [ADDR_WIDTH-1:0] iss_addr_reg;
  logic [DAT_WIDTH-1:0]  iss_dat_reg;
  logic [NUM_BYTE-1:0]   iss_be_reg;

  logic [MEM_DELAY-1:0]            dly_val_reg;
  logic [MEM_DELAY-1:0][TAG_W-1:0] dly_tag_reg;

  // A write wins over a simultaneous read on the same channel.
  assign req_any = req_wren | req_rden;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr_arbiter (
    .req   (req_any),
    .ptr   (ptr_reg),
    .grant (grant)
  );

  assign req_rdy = rst ? '0 : grant;
  assign accept  = ~rst & (|grant);
  assign gnt_wr  = |(grant & req_wren);

  // AND-OR mux of the granted channel's fields; grant is one-hot or zero.
  assign tag_chain[0]  = '0;
  assign addr_chain[0] = '0;
  assign dat_chain[0]  = '0;
  assign be_chain[0]   = '0;
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_mux
      assign tag_chain[gi+1]  = tag_chain[gi]  | (grant[gi] ? TAG_W'(gi) : '0);
      assign addr_chain[gi+1] = addr_chain[gi] |
                                (grant[gi] ? req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH] : '0);
      assign dat_chain[gi+1]  = dat_chain[gi] |
                                (grant[gi] ? req_idat[gi*DAT_WIDTH +: DAT_WIDTH] : '0);
      assign be_chain[gi+1]   = be_chain[gi] |
                                (grant[gi] ? req_be[gi*NUM_BYTE +: NUM_BYTE] : '0);
    end
  endgenerate

  always_comb begin
    ptr_next = ptr_reg;
    if (accept) begin
      ptr_next = (tag_chain[NUM_CH] == TAG_W'(NUM_CH-1)) ? '0
                                                          : tag_chain[NUM_CH] + TAG_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg     <= '0;
      iss_val_reg <= 1'b0;
    end else begin
      ptr_reg     <= ptr_next;
      iss_val_reg <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      iss_op_reg   <= gnt_wr ? OP_WRITE : OP_READ;
      iss_tag_reg  <= tag_chain[NUM_CH];
      iss_addr_reg <= addr_chain[NUM_CH] << ADDR_MODE;
      iss_dat_reg  <= dat_chain[NUM_CH];
      iss_be_reg   <= be_chain[NUM_CH];
    end
  end

  assign mem_addr = iss_addr_reg;
  assign mem_idat = iss_dat_reg;
  assign mem_enb  = iss_val_reg;
  assign mem_wren = (iss_val_reg && iss_op_reg == OP_WRITE) ? iss_be_reg : '0;
  assign mem_rst  = rst;

  // Read tags ride alongside the BRAM latency; the last stage lines up with mem_odat.
  generate
    for (genvar gi = 0; gi < MEM_DELAY; gi++) begin : g_dly
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          dly_tag_reg[gi] <= iss_tag_reg;
          if (rst) dly_val_reg[gi] <= 1'b0;
          else     dly_val_reg[gi] <= iss_val_reg && (iss_op_reg == OP_READ);
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          dly_tag_reg[gi] <= dly_tag_reg[gi-1];
          if (rst) dly_val_reg[gi] <= 1'b0;
          else     dly_val_reg[gi] <= dly_val_reg[gi-1];
        end
      end
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_out
      assign oval[gi] = dly_val_reg[MEM_DELAY-1] && (dly_tag_reg[MEM_DELAY-1] == TAG_W'(gi));
`ifdef BRAM_ARB_CTRL_ODAT_HOLD_EN
      logic [DAT_WIDTH-1:0] hold_reg;
      always_ff @(posedge clk) begin
        if (rst)           hold_reg <= '0;
        else if (oval[gi]) hold_reg <= mem_odat;
      end
      assign odat[gi*DAT_WIDTH +: DAT_WIDTH] = oval[gi] ? mem_odat : hold_reg;
`else
      assign odat[gi*DAT_WIDTH +: DAT_WIDTH] = oval[gi] ? mem_odat : '0;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_bram_arb_ctrl.sv
// Directed self-checking bench for bram_arb_ctrl (NUM_CH=4, MEM_DELAY=2)
// with a byte-enable BRAM model of two-cycle read latency.
module tb_bram_arb_ctrl;

`ifdef BRAM_ARB_CTRL_ODAT_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] req_addr;
  logic [3:0]   req_wren;
  logic [15:0]  req_be;
  logic [127:0] req_idat;
  logic [3:0]   req_rden;
  logic [3:0]   req_rdy;
  logic [127:0] odat;
  logic [3:0]   oval;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_idat;
  logic [31:0]  mem_odat;
  logic [3:0]   mem_wren;
  logic         mem_enb;
  logic         mem_rst;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_last [4];
  logic [31:0] tb_mem [256];
  logic [31:0] rd_p1, rd_p2;

  // Expected grant and returning channel per cycle for four continuous readers.
  int         exp_och   [9] = '{-1, -1, -1, 0, 1, 2, 3, 0, 1};
  logic [3:0] exp_rdy_t [9] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h0, 4'h0, 4'h0};

  always #5 clk = ~clk;

  bram_arb_ctrl #(
    .NUM_CH(4), .DAT_WIDTH(32), .ADDR_WIDTH(32), .ADDR_MODE(2), .MEM_DELAY(2)
  ) dut (
    .clk(clk), .rst(rst), .req_addr(req_addr), .req_wren(req_wren), .req_be(req_be),
    .req_idat(req_idat), .req_rden(req_rden), .req_rdy(req_rdy), .odat(odat), .oval(oval),
    .mem_addr(mem_addr), .mem_idat(mem_idat), .mem_odat(mem_odat), .mem_wren(mem_wren),
    .mem_enb(mem_enb), .mem_rst(mem_rst)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i >= 32 && i <= 35) return 32'hC0DE_0000 + 32'(i - 32);
    if (i == 48) return 32'h0000_1234;
    return 32'h0;
  endfunction

  function automatic logic [31:0] bmask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  always @(posedge clk) begin
    if (mem_rst) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= init_word(i);
      rd_p1 <= '0;
      rd_p2 <= '0;
    end else begin
      if (mem_enb) begin
        tb_mem[mem_addr[9:2]] <= (tb_mem[mem_addr[9:2]] & ~bmask(mem_wren)) |
                                 (mem_idat & bmask(mem_wren));
        rd_p1 <= tb_mem[mem_addr[9:2]];
      end
      rd_p2 <= rd_p1;
    end
  end
  assign mem_odat = rd_p2;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ch < 0 means no read data is due in this cycle.
  task automatic check_out(input string tag, input int ch, input logic [31:0] data);
    logic [3:0]   eo;
    logic [127:0] eod;
    eo  = (ch < 0) ? 4'h0 : 4'(1 << ch);
    eod = '0;
    for (int i = 0; i < 4; i++) begin
      if (eo[i]) begin
        eod[i*32 +: 32] = data;
        exp_last[i]     = data;
      end else begin
        eod[i*32 +: 32] = HOLD ? exp_last[i] : 32'h0;
      end
    end
    chk({tag, "_oval"}, 128'(oval), 128'(eo));
    chk({tag, "_odat"}, odat, eod);
    $display("cycle %s: oval=%b odat=%h", tag, oval, odat);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    req_wren = '0; req_rden = '0; req_be = '0; req_idat = '0; req_addr = '0;
  endtask

  task automatic set_req(input int ch, input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] dat);
    req_rden = req_rden | (4'(rd) << ch);
    req_wren = req_wren | (4'(wr) << ch);
    req_addr = req_addr | (128'(addr) << (32 * ch));
    req_be   = req_be   | (16'(be) << (4 * ch));
    req_idat = req_idat | (128'(dat) << (32 * ch));
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    check_out(tag, -1, 32'h0);
    next_cyc();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) exp_last[i] = '0;
    rst = 1'b1;
    clr();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 32'h20 + 32'(i), 4'h0, 32'h0);

    // Reset: requests present but nothing granted or issued.
    @(negedge clk);
    chk("rst_rdy", 128'(req_rdy), 128'(4'h0));
    chk("rst_enb", 128'(mem_enb), 128'(1'b0));
    chk("rst_memrst", 128'(mem_rst), 128'(1'b1));
    check_out("rst", -1, 32'h0);
    next_cyc();
    rst = 1'b0;

    // Four continuous readers from reset.
    for (int k = 0; k < 9; k++) begin
      if (k == 6) clr();
      @(negedge clk);
      if (k == 0) chk("run_memrst", 128'(mem_rst), 128'(1'b0));
      chk($sformatf("rr%0d_rdy", k), 128'(req_rdy), 128'(exp_rdy_t[k]));
      check_out($sformatf("rr%0d", k), exp_och[k],
                (exp_och[k] < 0) ? 32'h0 : init_word(32 + exp_och[k]));
      next_cyc();
    end

    // Single write from ch1.
    set_req(1, 1'b0, 1'b1, 32'h10, 4'b0011, 32'hA5A5_A5A5);
    @(negedge clk);
    chk("wr_rdy", 128'(req_rdy), 128'(4'b0010));
    next_cyc();
    clr();
    @(negedge clk);
    chk("wr_addr", 128'(mem_addr), 128'(32'h40));
    chk("wr_wren", 128'(mem_wren), 128'(4'b0011));
    chk("wr_enb", 128'(mem_enb), 128'(1'b1));
    chk("wr_idat", 128'(mem_idat), 128'(32'hA5A5_A5A5));
    check_out("wr_iss", -1, 32'h0);
    next_cyc();
    for (int k = 0; k < 3; k++) idle_chk($sformatf("wr_idle%0d", k));

    // Read back on ch2: only the enabled bytes were written.
    set_req(2, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    @(negedge clk);
    chk("rd2_rdy", 128'(req_rdy), 128'(4'b0100));
    next_cyc();
    clr();
    @(negedge clk);
    chk("rd2_enb", 128'(mem_enb), 128'(1'b1));
    chk("rd2_wren", 128'(mem_wren), 128'(4'b0000));
    chk("rd2_addr", 128'(mem_addr), 128'(32'h40));
    next_cyc();
    idle_chk("rd2_t2");
    @(negedge clk);
    check_out("rd2_t3", 2, 32'h0000_A5A5);
    next_cyc();

    // Read on ch3, then idle: odat behaviour depends on the hold option.
    set_req(3, 1'b1, 1'b0, 32'h30, 4'h0, 32'h0);
    @(negedge clk);
    chk("rd3_rdy", 128'(req_rdy), 128'(4'b1000));
    next_cyc();
    clr();
    idle_chk("rd3_t1");
    idle_chk("rd3_t2");
    @(negedge clk);
    check_out("rd3_t3", 3, 32'h0000_1234);
    next_cyc();
    idle_chk("rd3_after");

    // Write and read together on ch0: issued as a write, no data return.
    set_req(0, 1'b1, 1'b1, 32'h08, 4'hF, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("wrd_rdy", 128'(req_rdy), 128'(4'b0001));
    next_cyc();
    clr();
    @(negedge clk);
    chk("wrd_wren", 128'(mem_wren), 128'(4'hF));
    chk("wrd_enb", 128'(mem_enb), 128'(1'b1));
    chk("wrd_addr", 128'(mem_addr), 128'(32'h20));
    next_cyc();
    for (int k = 0; k < 3; k++) idle_chk($sformatf("wrd_idle%0d", k));

    // Pointer at 1: ch3 beats ch0, then ch0 is served.
    set_req(0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
    set_req(3, 1'b1, 1'b0, 32'h23, 4'h0, 32'h0);
    @(negedge clk);
    chk("arb_a_rdy", 128'(req_rdy), 128'(4'b1000));
    next_cyc();
    clr();
    set_req(0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
    @(negedge clk);
    chk("arb_b_rdy", 128'(req_rdy), 128'(4'b0001));
    check_out("arb_b", -1, 32'h0);
    next_cyc();
    clr();
    idle_chk("arb_c");
    @(negedge clk);
    check_out("arb_d", 3, 32'hC0DE_0003);
    next_cyc();
    @(negedge clk);
    check_out("arb_e", 0, 32'hC0DE_0000);
    next_cyc();
    idle_chk("arb_f");

    // Reset right after a read is accepted drops it and rewinds the pointer.
    set_req(1, 1'b1, 1'b0, 32'h21, 4'h0, 32'h0);
    @(negedge clk);
    chk("flush_rdy", 128'(req_rdy), 128'(4'b0010));
    next_cyc();
    clr();
    set_req(2, 1'b1, 1'b0, 32'h22, 4'h0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("flush_rst_rdy", 128'(req_rdy), 128'(4'h0));
    chk("flush_memrst", 128'(mem_rst), 128'(1'b1));
    next_cyc();
    rst = 1'b0;
    clr();
    for (int i = 0; i < 4; i++) exp_last[i] = '0;
    for (int k = 0; k < 4; k++) idle_chk($sformatf("flush_idle%0d", k));
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 32'h20 + 32'(i), 4'h0, 32'h0);
    @(negedge clk);
    chk("post_rst_rdy", 128'(req_rdy), 128'(4'b0001));
    next_cyc();
    clr();
    idle_chk("post_t1");
    idle_chk("post_t2");
    @(negedge clk);
    check_out("post_t3", 0, 32'hC0DE_0000);
    next_cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
